unsat_clause_collector: RTL

// - Producer side of the selector's FIFO interface: after each variable flip, the clause-evaluation pipeline streams every

---
 rtl/ucc_pkg.sv | 21 ++
 rtl/ucc_fifo.sv | 71 +++++++
 rtl/unsat_clause_collector.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ucc_pkg.sv
// Shared widths, FSM state encoding and queue entry payload for the unsat clause collector.
package ucc_pkg;

    localparam int unsigned NSAT                  = 3;
    localparam int unsigned LITERAL_ADDRESS_WIDTH = 12;
    localparam int unsigned CLAUSE_WIDTH          = NSAT * LITERAL_ADDRESS_WIDTH;
    localparam int unsigned TRUE_CNT_WIDTH        = $clog2(NSAT + 1);
    localparam int unsigned UCC_FIFO_DEPTH        = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } ucc_state_e;

    typedef struct packed {
        logic                    last;
        logic [CLAUSE_WIDTH-1:0] clause;
    } ucc_entry_t;

endpackage

// File: rtl/ucc_fifo.sv
// First-word-fall-through clause queue from registered storage, with per-entry last flags
// and a port that marks the current tail entry as last of its batch in place.
module ucc_fifo
    import ucc_pkg::*;
#(
    parameter int unsigned DEPTH = UCC_FIFO_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned PW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  ucc_entry_t    push_entry_i,
    input  logic          pop_i,
    input  logic          set_tail_last_i,
    output logic          empty_o,
    output logic          full_o,
    output logic [PW-1:0] count_o,
    output ucc_entry_t    head_o
);

    logic [CLAUSE_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]        last_q;
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [AW-1:0]           wr_idx;
    logic [AW-1:0]           rd_idx;
    logic [AW-1:0]           tail_idx;
    logic                    do_push;
    logic                    do_pop;

    assign wr_idx   = wr_ptr_q[AW-1:0];
    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign tail_idx = AW'(wr_ptr_q - PW'(1));

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign count_o  = wr_ptr_q - rd_ptr_q;

    assign do_push  = push_i & ~full_o;
    assign do_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Clause payload needs no reset: the head is gated while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_idx] <= push_entry_i.clause;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= '0;
        end else begin
            if (set_tail_last_i && !empty_o) last_q[tail_idx] <= 1'b1;
            if (do_push)                     last_q[wr_idx]   <= push_entry_i.last;
        end
    end

    assign head_o.clause = empty_o ? '0 : mem_q[rd_idx];
    assign head_o.last   = ~empty_o & last_q[rd_idx];

endmodule

// File: rtl/unsat_clause_collector.sv
// Keeps only clauses with zero true literals from each flip batch and queues them for the selector.
// Optional UNSAT_CLAUSE_COLLECTOR_STATS_EN adds saturating pushed/filtered beat counters.
module unsat_clause_collector
    import ucc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = UCC_FIFO_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flip_start_i,
    input  logic                      eval_valid_i,
    output logic                      eval_ready_o,
    input  logic [CLAUSE_WIDTH-1:0]   eval_clause_i,
    input  logic [TRUE_CNT_WIDTH-1:0] eval_true_cnt_i,
    input  logic                      eval_last_i,
    input  logic                      fifo_pop_i,
    output logic                      fifo_empty_o,
    output logic [CLAUSE_WIDTH-1:0]   fifo_clause_o,
    output logic                      fifo_last_o,
    output logic                      batch_empty_o,
    output logic                      busy_o,
    output logic                      underflow_o
`ifdef UNSAT_CLAUSE_COLLECTOR_STATS_EN
    ,
    output logic [31:0]               stat_pushed_o,
    output logic [31:0]               stat_filtered_o
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;

    ucc_state_e       state_q;
    ucc_state_e       state_d;
    ucc_entry_t       push_entry;
    ucc_entry_t       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W-1:0] fifo_count;
    logic [PTR_W-1:0] count_after_pop;
    logic             accept;
    logic             push;
    logic             filtered;
    logic             last_filtered;
    logic             pop_eff;
    logic             set_tail;
    logic             batch_empty_d;
    logic             batch_empty_q;
    logic             underflow_q;

    assign pop_eff         = fifo_pop_i & ~fifo_empty;
    assign count_after_pop = fifo_count - PTR_W'(pop_eff);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and beat acceptance; ready depends only on registered state and count.
    always_comb begin
        state_d      = state_q;
        eval_ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flip_start_i) state_d = COLLECT;
            end
            COLLECT: begin
                eval_ready_o = ~fifo_full;
                if (eval_valid_i && !fifo_full && eval_last_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (count_after_pop == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept        = eval_valid_i & eval_ready_o;
    assign push          = accept & (eval_true_cnt_i == '0);
    assign filtered      = accept & (eval_true_cnt_i != '0);
    assign last_filtered = filtered & eval_last_i;

    // A tail being popped this cycle cannot carry the marker, so it counts as nothing left.
    assign set_tail      = last_filtered & (count_after_pop != '0);
    assign batch_empty_d = last_filtered & (count_after_pop == '0);

    assign push_entry.last   = eval_last_i;
    assign push_entry.clause = eval_clause_i;

    ucc_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .push_i          (push),
        .push_entry_i    (push_entry),
        .pop_i           (fifo_pop_i),
        .set_tail_last_i (set_tail),
        .empty_o         (fifo_empty),
        .full_o          (fifo_full),
        .count_o         (fifo_count),
        .head_o          (head)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            batch_empty_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            batch_empty_q <= batch_empty_d;
            underflow_q   <= underflow_q | (fifo_pop_i & fifo_empty);
        end
    end

    assign fifo_empty_o  = fifo_empty;
    assign fifo_clause_o = head.clause;
    assign fifo_last_o   = head.last;
    assign batch_empty_o = batch_empty_q;
    assign busy_o        = (state_q != IDLE);
    assign underflow_o   = underflow_q;

`ifdef UNSAT_CLAUSE_COLLECTOR_STATS_EN
    logic [31:0] stat_pushed_q;
    logic [31:0] stat_filtered_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_pushed_q   <= '0;
            stat_filtered_q <= '0;
        end else begin
            if (push && (stat_pushed_q != '1))       stat_pushed_q   <= stat_pushed_q + 32'd1;
            if (filtered && (stat_filtered_q != '1)) stat_filtered_q <= stat_filtered_q + 32'd1;
        end
    end

    assign stat_pushed_o   = stat_pushed_q;
    assign stat_filtered_o = stat_filtered_q;
`endif

endmodule
